ring_ctr_monitor: RTL and testbench

- Downstream checker for the one-hot ring counter. Samples the counter's output every enabled cycle and confirms that it stays one-hot and rotates one position per step.
- Locks onto a valid sequence, counts full revolutions and reports phase index.
- Flags and counts rotation faults for the system status path.

---
 rtl/ring_ctr_monitor.sv | 172 +++++++++++++++++
 tb/tb_ring_ctr_monitor.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_ctr_monitor.sv
// Checker for a one-hot ring counter: locks onto a clean rotation sequence,
// counts revolutions and flags loss of lock as a counted, sticky fault.
module ring_ctr_monitor #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SYNC_LEN = 2,
    parameter int unsigned REV_W    = 8,
    parameter int unsigned ERR_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clr_err,
    output logic                     locked,
    output logic                     fault,
    output logic                     err_sticky,
    output logic [ERR_W-1:0]         err_cnt,
    output logic [REV_W-1:0]         rev_cnt,
    output logic                     rev_pulse,
    output logic [$clog2(WIDTH)-1:0] phase_idx
);

    localparam int unsigned IDX_W  = $clog2(WIDTH);
    localparam int unsigned SYNC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        LOCK  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [SYNC_W-1:0] sync_q, sync_d;
    logic [REV_W-1:0]  rev_d;
    logic [ERR_W-1:0]  err_d;
    logic              sticky_d;
    logic [IDX_W-1:0]  phase_d;
    logic              fault_d;
    logic              pulse_d;

    logic [WIDTH-1:0]  rot_c;
    logic              match_c;
    logic              onehot_c;
    logic [IDX_W-1:0]  idx_c;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic logic [IDX_W-1:0] bit_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Sample classification against the expected left rotation of the last sample
    always_comb begin
        rot_c    = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
        match_c  = (ring_in == rot_c);
        onehot_c = is_onehot(ring_in);
        idx_c    = bit_index(ring_in);
    end

    // Next-state, counters and pulse outputs
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        sync_d   = sync_q;
        rev_d    = rev_cnt;
        err_d    = err_cnt;
        sticky_d = err_sticky;
        phase_d  = phase_idx;
        fault_d  = 1'b0;
        pulse_d  = 1'b0;

        if (en) prev_d = ring_in;

        case (state_q)
            IDLE: begin
                if (en && onehot_c) begin
                    state_d = SYNC;
                    sync_d  = '0;
                end
            end
            SYNC: begin
                if (en) begin
                    if (match_c) begin
                        if (sync_q == SYNC_LAST) begin
                            state_d = LOCK;
                            phase_d = idx_c;
                        end else begin
                            sync_d = sync_q + SYNC_W'(1);
                        end
                    end else if (onehot_c) begin
                        sync_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCK: begin
                if (en) begin
                    if (match_c) begin
                        phase_d = idx_c;
                        if (ring_in[0]) begin
                            pulse_d = 1'b1;
                            rev_d   = rev_cnt + REV_W'(1);
                        end
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            FAULT: begin
                // Single recovery cycle, taken whether or not en is asserted
                state_d = onehot_c ? SYNC : IDLE;
                sync_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        // A fault on the same edge as a clear leaves a count of one
        if (clr_err) begin
            err_d    = '0;
            sticky_d = 1'b0;
        end
        if (fault_d) begin
            sticky_d = 1'b1;
            if (err_d != ERR_MAX) err_d = err_d + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            sync_q     <= '0;
            rev_cnt    <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
            phase_idx  <= '0;
            fault      <= 1'b0;
            rev_pulse  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            sync_q     <= sync_d;
            rev_cnt    <= rev_d;
            err_cnt    <= err_d;
            err_sticky <= sticky_d;
            phase_idx  <= phase_d;
            fault      <= fault_d;
            rev_pulse  <= pulse_d;
            locked     <= (state_d == LOCK);
        end
    end

endmodule

// File: tb/tb_ring_ctr_monitor.sv
// Randomized and directed bench for ring_ctr_monitor against a behavioural model.
module tb_ring_ctr_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] ring_in;
    logic       clr_err;
    logic       locked;
    logic       fault;
    logic       err_sticky;
    logic [3:0] err_cnt;
    logic [7:0] rev_cnt;
    logic       rev_pulse;
    logic [1:0] phase_idx;

    int checks;
    int failures;

    ring_ctr_monitor #(
        .WIDTH(4), .SYNC_LEN(2), .REV_W(8), .ERR_W(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ring_in(ring_in), .clr_err(clr_err),
        .locked(locked), .fault(fault), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .rev_cnt(rev_cnt), .rev_pulse(rev_pulse),
        .phase_idx(phase_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 hunting, 2 locked, 3 recovering
    int         m_mode;
    int         m_run;
    logic [3:0] m_prev;
    logic [7:0] m_rev;
    logic [3:0] m_err;
    logic       m_sticky;
    logic [1:0] m_phase;
    logic       m_fault;
    logic       m_pulse;
    logic       m_locked;

    function automatic logic [3:0] rot(input logic [3:0] x);
        int v;
        v = int'(x);
        return 4'(((v * 2) % 16) + (v / 8));
    endfunction

    task automatic model_update(input logic e, input logic [3:0] r, input logic c, input logic rs);
        bit one;
        bit hit;
        if (rs) begin
            m_mode = 0; m_run = 0; m_prev = 0; m_rev = 0; m_err = 0;
            m_sticky = 0; m_phase = 0; m_fault = 0; m_pulse = 0; m_locked = 0;
            return;
        end
        one = ($countones(r) == 1);
        hit = (r == rot(m_prev));
        m_fault = 0;
        m_pulse = 0;
        if (m_mode == 3) begin
            m_mode = one ? 1 : 0;
            m_run = 0;
        end else if (e) begin
            if (m_mode == 0) begin
                if (one) begin m_mode = 1; m_run = 0; end
            end else if (m_mode == 1) begin
                if (hit) begin
                    m_run++;
                    if (m_run == 2) begin m_mode = 2; m_phase = 2'($clog2(r)); end
                end else if (one) m_run = 0;
                else m_mode = 0;
            end else begin
                if (hit) begin
                    m_phase = 2'($clog2(r));
                    if (r == 4'b0001) begin m_pulse = 1; m_rev = m_rev + 8'd1; end
                end else begin
                    m_mode = 3;
                    m_fault = 1;
                end
            end
        end
        if (e) m_prev = r;
        if (c) begin m_err = 0; m_sticky = 0; end
        if (m_fault) begin
            m_sticky = 1;
            if (m_err != 4'd15) m_err = m_err + 4'd1;
        end
        m_locked = (m_mode == 2);
    endtask

    function automatic logic [17:0] pack_act();
        return {locked, fault, err_sticky, err_cnt, rev_cnt, rev_pulse, phase_idx};
    endfunction

    function automatic logic [17:0] pack_exp();
        return {m_locked, m_fault, m_sticky, m_err, m_rev, m_pulse, m_phase};
    endfunction

    // One clock: drive inputs, advance model at the edge, settle for sampling
    task automatic step(input logic e, input logic [3:0] r, input logic c, input logic rs);
        en = e; ring_in = r; clr_err = c; rst = rs;
        @(posedge clk);
        model_update(e, r, c, rs);
        #1;
    endtask

    task automatic fault_relock();
        step(1, 4'b1111, 0, 0);
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0010, 0, 0);
        step(1, 4'b0100, 0, 0);
    endtask

    task automatic test_reset();
        step(0, 4'b0000, 0, 1);
        step(0, 4'b0000, 0, 1);
        checks++;
        if (pack_act() !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs act=%h exp=%h", pack_act(), 18'd0);
        end
    endtask

    task automatic test_lock_count();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            step(1, seq[i], 0, 0);
            checks++;
            if (pack_act() !== pack_exp()) begin
                failures++;
                $display("FAIL lock_seq[%0d] act=%h exp=%h", i, pack_act(), pack_exp());
            end
            if (i == 1) begin
                checks++;
                if (locked !== 1'b0) begin
                    failures++;
                    $display("FAIL lock_early act=%b exp=0", locked);
                end
            end
            if (i == 2) begin
                checks++;
                if (locked !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_at_0100 act=%b exp=1", locked);
                end
            end
            if (i == 3) begin
                checks++;
                if (phase_idx !== 2'd3) begin
                    failures++;
                    $display("FAIL phase_at_1000 act=%0d exp=3", phase_idx);
                end
            end
        end
        checks++;
        if (rev_pulse !== 1'b1 || rev_cnt !== 8'd1) begin
            failures++;
            $display("FAIL first_rev act=%b/%0d exp=1/1", rev_pulse, rev_cnt);
        end
        step(1, 4'b0010, 0, 0);
        checks++;
        if (rev_pulse !== 1'b0 || rev_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rev_pulse_width act=%b/%0d exp=0/1", rev_pulse, rev_cnt);
        end
    endtask

    task automatic test_fault();
        step(1, 4'b0100, 0, 0);
        step(1, 4'b0011, 0, 0);
        checks++;
        if ({fault, locked, err_cnt, err_sticky} !== {1'b1, 1'b0, 4'd1, 1'b1}) begin
            failures++;
            $display("FAIL fault_detect act=%b%b/%0d/%b exp=10/1/1", fault, locked, err_cnt, err_sticky);
        end
        step(1, 4'b0011, 0, 0);
        checks++;
        if (fault !== 1'b0 || pack_act() !== pack_exp()) begin
            failures++;
            $display("FAIL fault_one_cycle act=%h exp=%h", pack_act(), pack_exp());
        end
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0010, 0, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL relock_early act=%b exp=0", locked);
        end
        step(1, 4'b0100, 0, 0);
        checks++;
        if (locked !== 1'b1 || pack_act() !== pack_exp()) begin
            failures++;
            $display("FAIL relock act=%h exp=%h", pack_act(), pack_exp());
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            fault_relock();
            checks++;
            if (pack_act() !== pack_exp()) begin
                failures++;
                $display("FAIL sat_loop[%0d] act=%h exp=%h", i, pack_act(), pack_exp());
            end
        end
        checks++;
        if (err_cnt !== 4'd15 || err_sticky !== 1'b1) begin
            failures++;
            $display("FAIL err_saturate act=%0d/%b exp=15/1", err_cnt, err_sticky);
        end
        step(0, 4'b0000, 1, 0);
        checks++;
        if (err_cnt !== 4'd0 || err_sticky !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL err_clear act=%0d/%b/%b exp=0/0/1", err_cnt, err_sticky, locked);
        end
    endtask

    task automatic test_en_hold();
        logic [7:0] rev_saved;
        step(1, 4'b1000, 0, 0);
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0010, 0, 0);
        rev_saved = m_rev;
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b0000, 0, 0);
            checks++;
            if (locked !== 1'b1 || fault !== 1'b0 || rev_cnt !== rev_saved) begin
                failures++;
                $display("FAIL en_hold[%0d] act=%b%b/%0d exp=10/%0d", i, locked, fault, rev_cnt, rev_saved);
            end
        end
        step(1, 4'b0100, 0, 0);
        checks++;
        if (locked !== 1'b1 || phase_idx !== 2'd2) begin
            failures++;
            $display("FAIL en_resume act=%b/%0d exp=1/2", locked, phase_idx);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        for (int i = 0; i < 7; i++) fault_relock();
        checks++;
        if (err_cnt !== 4'd7) begin
            failures++;
            $display("FAIL err_seven act=%0d exp=7", err_cnt);
        end
        step(1, 4'b1111, 1, 0);
        checks++;
        if (err_cnt !== 4'd1 || err_sticky !== 1'b1 || fault !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_fault act=%0d/%b/%b exp=1/1/1", err_cnt, err_sticky, fault);
        end
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0010, 0, 0);
        step(1, 4'b0100, 0, 0);
        guard = 0;
        while (m_rev != 8'd255 && guard < 3000) begin
            step(1, rot(m_prev), 0, 0);
            guard++;
        end
        while (rot(m_prev) != 4'b0001 && guard < 3000) begin
            step(1, rot(m_prev), 0, 0);
            guard++;
        end
        checks++;
        if (rev_cnt !== 8'd255 || guard >= 3000) begin
            failures++;
            $display("FAIL rev_reach_255 act=%0d exp=255 steps=%0d", rev_cnt, guard);
        end
        step(1, 4'b0001, 0, 0);
        checks++;
        if (rev_cnt !== 8'd0 || rev_pulse !== 1'b1) begin
            failures++;
            $display("FAIL rev_wrap act=%0d/%b exp=0/1", rev_cnt, rev_pulse);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        step(0, 4'b0000, 0, 1);
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0010, 0, 0);
        step(1, 4'b0100, 0, 0);
        fault_relock();
        fault_relock();
        guard = 0;
        while (m_rev != 8'd3 && guard < 100) begin
            step(1, rot(m_prev), 0, 0);
            guard++;
        end
        checks++;
        if (locked !== 1'b1 || rev_cnt !== 8'd3 || err_cnt !== 4'd2) begin
            failures++;
            $display("FAIL pre_reset act=%b/%0d/%0d exp=1/3/2", locked, rev_cnt, err_cnt);
        end
        step(1, rot(m_prev), 0, 1);
        checks++;
        if (pack_act() !== 18'd0) begin
            failures++;
            $display("FAIL reset_mid act=%h exp=%h", pack_act(), 18'd0);
        end
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0010, 0, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_early act=%b exp=0", locked);
        end
        step(1, 4'b0100, 0, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_lock act=%b exp=1", locked);
        end
    endtask

    task automatic test_random();
        logic       e;
        logic       c;
        logic       rs;
        logic [3:0] r;
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 99) < 80);
            c  = ($urandom_range(0, 99) < 5);
            rs = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 80) r = rot(m_prev);
            else if ($urandom_range(0, 1) == 1) r = 4'(1 << $urandom_range(0, 3));
            else r = 4'($urandom_range(0, 15));
            step(e, r, c, rs);
            checks++;
            if (pack_act() !== pack_exp()) begin
                failures++;
                $display("FAIL random[%0d] act=%h exp=%h", i, pack_act(), pack_exp());
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; en = 1'b0; ring_in = 4'b0000; clr_err = 1'b0;
        model_update(0, 4'b0000, 0, 1);
        test_reset();
        test_lock_count();
        test_fault();
        test_saturation();
        test_en_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
